// File: rtl/fib_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : fib_stream_checker
// Description : Consumer and self-check stage for a W-bit Fibonacci stream.
//               Samples fib_in on every enabled clock edge and checks each
//               term against next = (a + b) mod 2^W, pulsing match/mismatch,
//               counting terms and errors (saturating), and holding a sticky
//               error flag until reset.
//
// Parameters  : W           - data width of the Fibonacci stream
//               TERM_CNT_W  - width of the saturating term counter
//               ERR_CNT_W   - width of the saturating mismatch counter
//               STRICT_SEED - 1: first two terms must be 0 then 1
//                             0: accept any seed pair
//
// Ports       : clk        in   system clock, rising edge
//               rst        in   asynchronous active-high reset
//               en         in   sample qualifier (same enable as generator)
//               fib_in     in   [W]  term from the generator
//               match      out  one-cycle pulse, last sampled term correct
//               mismatch   out  one-cycle pulse, last sampled term wrong
//               err_sticky out  set on any mismatch, cleared only by rst
//               expected   out  [W]  prediction for the next sampled term
//               term_count out  [TERM_CNT_W] saturating sampled-term count
//               err_count  out  [ERR_CNT_W]  saturating mismatch count
//               state      out  [2]  0 IDLE, 1 SEED1, 2 CHECK
//
// Revision    : 1.0 - initial release
// ============================================================================
module fib_stream_checker #(
  parameter int W           = 4,
  parameter int TERM_CNT_W  = 8,
  parameter int ERR_CNT_W   = 8,
  parameter int STRICT_SEED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [W-1:0]          fib_in,
  output logic                  match,
  output logic                  mismatch,
  output logic                  err_sticky,
  output logic [W-1:0]          expected,
  output logic [TERM_CNT_W-1:0] term_count,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED1 = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t      st;
  // Most recent sampled term. The older term of the pair is not stored: the
  // prediction is formed at the moment the newer term arrives (b + fib_in),
  // so only the latest term is needed to continue the recurrence.
  logic [W-1:0] b;
  logic         term_ok;
  logic [W-1:0] next_sum;

  assign state = st;

  // Carry out of the W-bit add is discarded: wrap is legal Fibonacci mod 2^W.
  assign next_sum = b + fib_in;

  // Verdict for the term presented this cycle, used only when en is high.
  always_comb begin
    term_ok = 1'b1;
    case (st)
      IDLE:    if ((STRICT_SEED != 0) && (fib_in != '0)) term_ok = 1'b0;
      SEED1:   if ((STRICT_SEED != 0) && (fib_in != ONE)) term_ok = 1'b0;
      CHECK:   term_ok = (fib_in == expected);
      default: term_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      b          <= '0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      expected   <= '0;
      term_count <= '0;
      err_count  <= '0;
    end else begin
      // Pulses last exactly one cycle after a sample and are low otherwise.
      match    <= 1'b0;
      mismatch <= 1'b0;

      if (en) begin
        b <= fib_in;

        if (term_count != '1) begin
          term_count <= term_count + TERM_CNT_W'(1);
        end

        if (term_ok) begin
          match <= 1'b1;
        end else begin
          mismatch   <= 1'b1;
          err_sticky <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + ERR_CNT_W'(1);
          end
        end

        case (st)
          IDLE: begin
            st       <= SEED1;
            expected <= (STRICT_SEED != 0) ? ONE : fib_in;
          end
          SEED1: begin
            st       <= CHECK;
            expected <= next_sum;
          end
          CHECK: begin
            // Prediction always follows the observed terms, so a single
            // corrupted term re-locks after at most two further mismatches.
            st       <= CHECK;
            expected <= next_sum;
          end
          default: begin
            st       <= IDLE;
            expected <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fib_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_stream_checker
// Description : Directed self-checking bench for fib_stream_checker. One task
//               per scenario, each with hand-computed expected values.
//               dut uses default parameters; dut_sat uses TERM_CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_stream_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] fib_in;
  logic       match;
  logic       mismatch;
  logic       err_sticky;
  logic [3:0] expected;
  logic [7:0] term_count;
  logic [7:0] err_count;
  logic [1:0] state;

  logic       en2;
  logic [3:0] fib_in2;
  logic       match2;
  logic       mismatch2;
  logic       err_sticky2;
  logic [3:0] expected2;
  logic [1:0] term_count2;
  logic [7:0] err_count2;
  logic [1:0] state2;

  int checks;
  int failures;

  fib_stream_checker #(
    .W(4), .TERM_CNT_W(8), .ERR_CNT_W(8), .STRICT_SEED(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fib_in(fib_in),
    .match(match), .mismatch(mismatch), .err_sticky(err_sticky),
    .expected(expected), .term_count(term_count), .err_count(err_count),
    .state(state)
  );

  fib_stream_checker #(
    .W(4), .TERM_CNT_W(2), .ERR_CNT_W(8), .STRICT_SEED(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en2), .fib_in(fib_in2),
    .match(match2), .mismatch(mismatch2), .err_sticky(err_sticky2),
    .expected(expected2), .term_count(term_count2), .err_count(err_count2),
    .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one term, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic e, input logic [3:0] v);
    en     = e;
    fib_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    en2 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({match, mismatch, err_sticky} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000", {match, mismatch, err_sticky});
    end
    checks++;
    if (expected !== 4'd0 || term_count !== 8'd0 || err_count !== 8'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL reset_regs: got exp=%0d tc=%0d ec=%0d st=%0d want 0 0 0 0",
               expected, term_count, err_count, state);
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [3:0] s  [16] = '{0,1,1,2,3,5,8,13,5,2,7,9,0,9,9,2};
    logic [3:0] ex [16] = '{1,1,2,3,5,8,13,5,2,7,9,0,9,9,2,11};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, s[i]);
      checks++;
      if (match !== 1'b1 || mismatch !== 1'b0) begin
        failures++;
        $display("FAIL stream_pulse[%0d]: got match=%b mismatch=%b want 1 0", i, match, mismatch);
      end
      checks++;
      if (expected !== ex[i]) begin
        failures++;
        $display("FAIL stream_expected[%0d]: got %0d want %0d", i, expected, ex[i]);
      end
    end
    checks++;
    if (term_count !== 8'd16 || err_count !== 8'd0 || err_sticky !== 1'b0 || state !== 2'd2) begin
      failures++;
      $display("FAIL stream_end: got tc=%0d ec=%0d sticky=%b st=%0d want 16 0 0 2",
               term_count, err_count, err_sticky, state);
    end
  endtask

  task automatic test_enable_gap();
    logic [3:0] s1 [8] = '{0,1,1,2,3,5,8,13};
    logic [3:0] s2 [3] = '{5,2,7};
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, s1[i]);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'd15);
      checks++;
      if (match !== 1'b0 || mismatch !== 1'b0) begin
        failures++;
        $display("FAIL gap_pulse[%0d]: got match=%b mismatch=%b want 0 0", i, match, mismatch);
      end
      checks++;
      if (term_count !== 8'd8 || expected !== 4'd5 || state !== 2'd2 || err_count !== 8'd0) begin
        failures++;
        $display("FAIL gap_hold[%0d]: got tc=%0d exp=%0d st=%0d ec=%0d want 8 5 2 0",
                 i, term_count, expected, state, err_count);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s2[i]);
      checks++;
      if (match !== 1'b1 || mismatch !== 1'b0) begin
        failures++;
        $display("FAIL gap_resume[%0d]: got match=%b mismatch=%b want 1 0", i, match, mismatch);
      end
    end
    checks++;
    if (term_count !== 8'd11 || expected !== 4'd9) begin
      failures++;
      $display("FAIL gap_end: got tc=%0d exp=%0d want 11 9", term_count, expected);
    end
  endtask

  task automatic test_bad_seed();
    logic [3:0] s  [3] = '{1,1,2};
    logic       wm [3] = '{1'b0,1'b1,1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s[i]);
      checks++;
      if (match !== wm[i] || mismatch !== ~wm[i]) begin
        failures++;
        $display("FAIL seed_pulse[%0d]: got match=%b mismatch=%b want %b %b",
                 i, match, mismatch, wm[i], ~wm[i]);
      end
    end
    checks++;
    if (err_count !== 8'd1 || err_sticky !== 1'b1 || term_count !== 8'd3 || expected !== 4'd3) begin
      failures++;
      $display("FAIL seed_end: got ec=%0d sticky=%b tc=%0d exp=%0d want 1 1 3 3",
               err_count, err_sticky, term_count, expected);
    end
  endtask

  task automatic test_corrupt();
    logic [3:0] s  [8] = '{0,1,1,2,4,5,8,13};
    logic       wm [8] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
    logic [3:0] ex [8] = '{1,1,2,3,6,9,13,5};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[i]);
      checks++;
      if (match !== wm[i] || mismatch !== ~wm[i]) begin
        failures++;
        $display("FAIL corrupt_pulse[%0d]: got match=%b mismatch=%b want %b %b",
                 i, match, mismatch, wm[i], ~wm[i]);
      end
      checks++;
      if (expected !== ex[i]) begin
        failures++;
        $display("FAIL corrupt_expected[%0d]: got %0d want %0d", i, expected, ex[i]);
      end
    end
    checks++;
    if (err_count !== 8'd3 || err_sticky !== 1'b1 || term_count !== 8'd8) begin
      failures++;
      $display("FAIL corrupt_end: got ec=%0d sticky=%b tc=%0d want 3 1 8",
               err_count, err_sticky, term_count);
    end
  endtask

  task automatic test_midstream_reset();
    logic [3:0] s [6] = '{0,1,1,2,3,5};
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, s[i]);
    // Assert reset between edges; outputs must clear before the next edge.
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || term_count !== 8'd0 || match !== 1'b0 || expected !== 4'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got st=%0d tc=%0d match=%b exp=%0d ec=%0d want 0 0 0 0 0",
               state, term_count, match, expected, err_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s[i]);
      checks++;
      if (match !== 1'b1 || mismatch !== 1'b0) begin
        failures++;
        $display("FAIL restart_pulse[%0d]: got match=%b mismatch=%b want 1 0", i, match, mismatch);
      end
    end
    checks++;
    if (term_count !== 8'd3 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL restart_end: got tc=%0d ec=%0d want 3 0", term_count, err_count);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] s  [6] = '{0,1,1,2,3,5};
    logic [1:0] tc [6] = '{2'd1,2'd2,2'd3,2'd3,2'd3,2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      en2     = 1'b1;
      fib_in2 = s[i];
      @(posedge clk);
      #1;
      checks++;
      if (term_count2 !== tc[i] || match2 !== 1'b1 || mismatch2 !== 1'b0) begin
        failures++;
        $display("FAIL sat_term[%0d]: got tc=%0d match=%b mismatch=%b want %0d 1 0",
                 i, term_count2, match2, mismatch2, tc[i]);
      end
    end
    en2 = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    fib_in   = 4'd0;
    en2      = 1'b0;
    fib_in2  = 4'd0;
    test_reset();
    test_stream();
    test_enable_gap();
    test_bad_seed();
    test_corrupt();
    test_midstream_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
